result_uart_tx: RTL



---
 rtl/uart_pkg.sv | 20 ++
 rtl/result_uart_tx_if.sv | 28 ++
 rtl/uart_tx_byte.sv | 53 +++++
 rtl/result_uart_tx.sv | 122 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the matrix-multiply UART link: timing defaults,
// matrix limits and the transmit sequencer state encoding.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 10417;
  localparam int MAX_DIM_DEF      = 10;
  localparam int DATA_W_DEF       = 16;
  localparam int ADDR_W_DEF       = 7;
  localparam int BYTES_PER_ELEM   = DATA_W_DEF / 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_FIN   = 3'd5
  } tx_state_t;

endpackage

// File: rtl/result_uart_tx_if.sv
// Control, result-memory and serial signals of the result transmitter.
// master = controller/memory side, slave = result_uart_tx.
interface result_uart_tx_if
  import uart_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              start;
    logic [3:0]        dim;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              tx;
    logic              busy;
    logic              done;
    tx_state_t         fsm_state;

    modport master (
        output start, dim, rd_data,
        input  rd_en, rd_addr, tx, busy, done, fsm_state
    );

    modport slave (
        input  start, dim, rd_data,
        output rd_en, rd_addr, tx, busy, done, fsm_state
    );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: one start bit, eight data bits LSB first, one stop bit,
// each held CLKS_PER_BIT clocks.
module uart_tx_byte
  import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_idx;
    logic [9:0]       shift;

    // Handshake: a byte transfers on a clock edge where byte_valid and
    // byte_ready are both high; byte_ready drops for the whole frame and
    // rises again in the cycle after the stop bit ends.
    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_ready <= 1'b1;
            tx         <= 1'b1;
            shift      <= '1;
            baud_cnt   <= '0;
            bit_idx    <= '0;
        end else if (byte_ready) begin
            if (byte_valid) begin
                byte_ready <= 1'b0;
                shift      <= {1'b1, byte_data, 1'b0};
                tx         <= 1'b0;
                baud_cnt   <= '0;
                bit_idx    <= '0;
            end
        end else if (baud_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            baud_cnt <= '0;
            if (bit_idx == 4'd9) begin
                byte_ready <= 1'b1;
                tx         <= 1'b1;
            end else begin
                bit_idx <= bit_idx + 4'd1;
                shift   <= {1'b1, shift[9:1]};
                tx      <= shift[1];
            end
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/result_uart_tx.sv
// Reads the dim x dim result matrix in row-major order and streams every
// element MSB byte first through the UART byte serialiser.
module result_uart_tx
  import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_DIM      = MAX_DIM_DEF,
    parameter int ADDR_W       = ADDR_W_DEF
) (
    input logic              clk,
    input logic              rst,
    result_uart_tx_if.slave  bus
);
    localparam int         BPE       = DATA_W / 8;
    localparam logic [7:0] LAST_BYTE = 8'(BPE - 1);

    tx_state_t         state;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [3:0]        dim_q;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_idx;
    logic [7:0]        dim_sq;
    logic [7:0]        byte_cnt;
    logic [DATA_W-1:0] hold;
    logic              byte_valid;
    logic              byte_ready;
    logic [7:0]        byte_data;
    logic              dim_ok;

    assign dim_ok    = (bus.dim != 4'd0) && (int'(bus.dim) <= MAX_DIM);
    assign dim_sq    = {4'd0, dim_q} * {4'd0, dim_q};
    assign last_idx  = ADDR_W'(dim_sq - 8'd1);
    // The holding register shifts left per byte, so the MSB byte is always on top.
    assign byte_data = hold[DATA_W-1 -: 8];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            dim_q      <= '0;
            idx        <= '0;
            byte_cnt   <= '0;
            hold       <= '0;
            byte_valid <= 1'b0;
        end else begin
            done  <= 1'b0;
            rd_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start && dim_ok) begin
                        dim_q   <= bus.dim;
                        busy    <= 1'b1;
                        idx     <= '0;
                        rd_addr <= '0;
                        rd_en   <= 1'b1;
                        state   <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_WAIT;
                ST_WAIT: begin
                    hold       <= bus.rd_data;
                    byte_cnt   <= '0;
                    byte_valid <= 1'b1;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (byte_ready) begin
                        if (byte_cnt == LAST_BYTE) begin
                            byte_valid <= 1'b0;
                            state      <= ST_NEXT;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                            hold     <= hold << 8;
                        end
                    end
                end
                ST_NEXT: begin
                    // Next element is prefetched while the last byte is still on the line;
                    // only the final element waits for its stop bit before done.
                    if (idx == last_idx) begin
                        if (byte_ready) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_FIN;
                        end
                    end else begin
                        idx     <= idx + 1'b1;
                        rd_addr <= idx + 1'b1;
                        rd_en   <= 1'b1;
                        state   <= ST_FETCH;
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk       (clk),
        .rst       (rst),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .tx        (bus.tx)
    );

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = rd_addr;
    assign bus.fsm_state = state;
endmodule
